// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_types_pkg : shared CPU word types used by pipeline payloads     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage
`default_nettype wire

// File: rtl/pipe_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_stage_pkg : state encoding and default widths for stage buffer |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package pipe_stage_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  localparam int DEF_DATA_W = $bits(cpu_types_pkg::word_t);
  localparam int DEF_SKID   = 1;
  localparam int DEF_CNT_W  = 16;
endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter : event counter that sticks at its all-ones value       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_stage_buf : valid/ready stage register, optional skid, flush   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pipe_stage_buf
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SKID   = DEF_SKID,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_state_t      r_state;
  stage_state_t      w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_q;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_release;

  assign w_out_valid = (r_state != EMPTY);
  assign out_valid   = w_out_valid;
  assign out_data    = r_main;
  assign w_accept    = in_valid & in_ready;
  assign w_release   = w_out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ONE;
            w_main_nxt  = in_data;
          end
        end
        ONE: begin
          if (w_accept && w_release) begin
            w_main_nxt = in_data;
          end else if (w_accept) begin
            // Only reachable with a skid slot; the latch variant cannot accept here.
            if (SKID != 0) w_state_nxt = TWO;
          end else if (w_release) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (w_release) begin
            w_state_nxt = ONE;
            w_main_nxt  = w_skid_q;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= EMPTY;
      r_main  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] r_skid;
      logic              r_in_ready;
      logic              w_skid_load;

      // Second entry lands in the skid slot while the head stays put.
      assign w_skid_load = ~flush & (r_state == ONE) & w_accept & ~w_release;

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_skid     <= '0;
          r_in_ready <= 1'b1;
        end else begin
          if (w_skid_load) r_skid <= in_data;
          r_in_ready <= (w_state_nxt != TWO);
        end
      end

      assign in_ready = r_in_ready;
      assign w_skid_q = r_skid;
    end else begin : g_latch
      assign in_ready = ~w_out_valid | out_ready;
      assign w_skid_q = '0;
    end
  endgenerate

  logic w_stall_inc;
  logic w_bubble_inc;
  logic w_flush_inc;

  assign w_stall_inc  = w_out_valid & ~out_ready;
  assign w_bubble_inc = ~w_out_valid & ~flush;
  assign w_flush_inc  = flush & w_out_valid;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (w_bubble_inc),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_stage_buf : skid and latch variants against a FIFO model     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_pipe_stage_buf;

  localparam int DATA_W  = 32;
  localparam int A_CNT_W = 16;
  localparam int B_CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT 0: skid variant, DUT 1: latch variant with narrow counters
  logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [DATA_W-1:0]  a_in_data, a_out_data;
  logic [A_CNT_W-1:0] a_stall, a_bubble, a_flcnt;
  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [DATA_W-1:0]  b_in_data, b_out_data;
  logic [B_CNT_W-1:0] b_stall, b_bubble, b_flcnt;

  pipe_stage_buf #(.DATA_W(DATA_W), .SKID(1), .CNT_W(A_CNT_W)) u_dut_skid (
    .CLK(clk), .RST(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(a_flush),
    .stall_cnt(a_stall), .bubble_cnt(a_bubble), .flush_cnt(a_flcnt)
  );

  pipe_stage_buf #(.DATA_W(DATA_W), .SKID(0), .CNT_W(B_CNT_W)) u_dut_latch (
    .CLK(clk), .RST(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush),
    .stall_cnt(b_stall), .bubble_cnt(b_bubble), .flush_cnt(b_flcnt)
  );

  // Stimulus per DUT
  logic        iv [2];
  logic [31:0] id [2];
  logic        ordy [2];
  logic        fl [2];

  // Reference model: a bounded FIFO of capacity 2 (skid) or 1 (latch)
  logic [31:0] mq [2][2];
  int          msz [2];
  logic [31:0] mlast [2];
  int          mstall [2], mbub [2], mfl [2];
  logic        macc [2];
  int          cmax [2];
  bit          is_skid [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_reset(input int k);
    msz[k] = 0; mlast[k] = '0;
    mstall[k] = 0; mbub[k] = 0; mfl[k] = 0; macc[k] = 1'b0;
  endtask

  function automatic logic pred_ready(input int k);
    if (is_skid[k]) return (msz[k] < 2);
    return (msz[k] == 0) || ordy[k];
  endfunction

  task automatic check_dut(input int k);
    logic        ov, ir;
    logic [31:0] od, sc, bc, fc;
    string       p;
    if (k == 0) begin
      ov = a_out_valid; ir = a_in_ready; od = a_out_data;
      sc = 32'(a_stall); bc = 32'(a_bubble); fc = 32'(a_flcnt);
      p = "skid";
    end else begin
      ov = b_out_valid; ir = b_in_ready; od = b_out_data;
      sc = 32'(b_stall); bc = 32'(b_bubble); fc = 32'(b_flcnt);
      p = "latch";
    end
    chk({p, ".out_valid"},  32'(ov), 32'(msz[k] > 0));
    chk({p, ".out_data"},   od, (msz[k] > 0) ? mq[k][0] : mlast[k]);
    chk({p, ".in_ready"},   32'(ir), 32'(pred_ready(k)));
    chk({p, ".stall_cnt"},  sc, 32'(mstall[k]));
    chk({p, ".bubble_cnt"}, bc, 32'(mbub[k]));
    chk({p, ".flush_cnt"},  fc, 32'(mfl[k]));
  endtask

  task automatic model_step(input int k);
    logic ov, rel, acc;
    if (rst) begin
      model_reset(k);
      return;
    end
    ov  = (msz[k] > 0);
    rel = ov & ordy[k];
    acc = iv[k] & pred_ready(k);
    if (ov && !ordy[k]) mstall[k] = sat_inc(mstall[k], cmax[k]);
    if (!ov && !fl[k])  mbub[k]   = sat_inc(mbub[k], cmax[k]);
    if (fl[k]) begin
      if (ov) mfl[k] = sat_inc(mfl[k], cmax[k]);
      msz[k]  = 0;
      macc[k] = 1'b0;
    end else begin
      if (rel) begin
        mq[k][0] = mq[k][1];
        msz[k]--;
      end
      if (acc) begin
        mq[k][msz[k]] = id[k];
        msz[k]++;
      end
      macc[k] = acc;
    end
    if (msz[k] > 0) mlast[k] = mq[k][0];
  endtask

  task automatic cycle();
    a_in_valid = iv[0]; a_in_data = id[0]; a_out_ready = ordy[0]; a_flush = fl[0];
    b_in_valid = iv[1]; b_in_data = id[1]; b_out_ready = ordy[1]; b_flush = fl[1];
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_dut(k);
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int k);
    iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b1; fl[k] = 1'b0;
  endtask

  initial begin
    is_skid[0] = 1'b1; cmax[0] = (1 << A_CNT_W) - 1;
    is_skid[1] = 1'b0; cmax[1] = (1 << B_CNT_W) - 1;
    for (int k = 0; k < 2; k++) begin
      idle(k);
      iv[k] = 1'b1; id[k] = 32'hDEAD_BEEF;
      model_reset(k);
    end

    // Reset held for two edges with a payload offered
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_data = 32'hDEAD_BEEF; a_out_ready = 1'b1; a_flush = 1'b0;
    b_in_valid = 1'b1; b_in_data = 32'hDEAD_BEEF; b_out_ready = 1'b1; b_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    idle(0); idle(1);
    cycle();

    // Back-to-back streaming through the skid variant
    for (int i = 1; i <= 8; i++) begin
      iv[0] = 1'b1; id[0] = 32'(i);
      cycle();
    end
    idle(0);
    repeat (3) cycle();

    // Fill the skid slot, hold off the third payload, then drain
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 32'hA; cycle();
    id[0] = 32'hB; cycle();
    id[0] = 32'hC;
    repeat (3) cycle();
    ordy[0] = 1'b1;
    begin
      int budget = 10;
      do begin
        cycle();
        budget--;
      end while (!macc[0] && budget > 0);
      if (!macc[0]) chk("skid.c_accept_timeout", 32'd0, 32'd1);
    end
    idle(0);
    repeat (4) cycle();

    // Flush while two entries are held, with a payload offered in the same cycle
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 32'h11; cycle();
    id[0] = 32'h22; cycle();
    chk("skid.reached_two", 32'(msz[0]), 32'd2);
    fl[0] = 1'b1; id[0] = 32'h5; cycle();
    idle(0);
    repeat (3) cycle();

    // Latch variant: hold one entry, then toggle out_ready while offering data
    ordy[1] = 1'b0; iv[1] = 1'b1; id[1] = 32'h100; cycle();
    for (int i = 0; i < 8; i++) begin
      ordy[1] = i[0];
      id[1]   = 32'h200 + 32'(i);
      cycle();
    end

    // Saturation of the narrow stall counter
    iv[1] = 1'b0; ordy[1] = 1'b0;
    repeat (20) cycle();
    idle(1);
    repeat (2) cycle();

    // Randomised traffic on both variants, with rare flushes and resets
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        id[k]   = $urandom;
        ordy[k] = (n < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
        fl[k]   = ($urandom_range(0, 19) == 0);
      end
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end

    // Reset in mid-operation while entries are held
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle(k); ordy[k] = 1'b0; iv[k] = 1'b1; id[k] = 32'h77 + 32'(k);
    end
    repeat (3) cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; idle(0); idle(1);
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
